// File: rtl/mem_arbiter.sv
// Two-master memory arbiter: m0 = instruction fetch (read only), m1 = load/store.
// Grants one access at a time to a single memory port; s_* is held until ack or timeout.
// Optional build macro ARB_RR_EN: round-robin between the masters on simultaneous requests
// (default: fixed priority, m1 wins).
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req_i,
  input  logic [31:0] m0_addr_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  input  logic [3:0]  m1_wstrb_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        s_req_o,
  output logic        s_we_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_wdata_o,
  output logic [3:0]  s_wstrb_o,
  input  logic        s_ack_i,
  input  logic [31:0] s_rdata_i,
  output logic        err_o,
  output logic        fetch_stall_o
);

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned STRB_W   = 4;
  localparam int unsigned CNT_W    = 8;
  localparam int unsigned CNT_LAST = TIMEOUT - 1;

  typedef enum logic [1:0] {IDLE, BUSY_M0, BUSY_M1} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                rv0_q, rv0_d, rv1_q, rv1_d, err_q, err_d;
  logic [DATA_W-1:0]   rd0_q, rd0_d, rd1_q, rd1_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   addr_q, addr_d, wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                arb_c, gnt0_c, gnt1_c, m1_prio_c;

`ifdef ARB_RR_EN
  // last_q = 1 means m1 was granted most recently
  logic                last_q, last_d;

  // m1 wins a tie only if m0 was granted last
  always_comb begin
    m1_prio_c = ~last_q;
  end
`else
  // Fixed priority: m1 always wins a tie
  always_comb begin
    m1_prio_c = 1'b1;
  end
`endif

  // Next-state, wait counter, response capture and arbitration
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rv0_d   = 1'b0;
    rv1_d   = 1'b0;
    err_d   = 1'b0;
    rd0_d   = rd0_q;
    rd1_d   = rd1_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    arb_c   = 1'b0;
    gnt0_c  = 1'b0;
    gnt1_c  = 1'b0;
`ifdef ARB_RR_EN
    last_d  = last_q;
`endif
    case (state_q)
      IDLE: arb_c = 1'b1;
      BUSY_M0, BUSY_M1: begin
        if (s_ack_i) begin
          if (state_q == BUSY_M0) begin
            rv0_d = 1'b1;
            rd0_d = s_rdata_i;
          end else begin
            rv1_d = 1'b1;
            rd1_d = s_rdata_i;
          end
          state_d = IDLE;
          arb_c   = 1'b1;
        end else if (cnt_q == CNT_W'(CNT_LAST)) begin
          // Timeout: complete with zero data, no re-arbitration this cycle
          if (state_q == BUSY_M0) begin
            rv0_d = 1'b1;
            rd0_d = '0;
          end else begin
            rv1_d = 1'b1;
            rd1_d = '0;
          end
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (arb_c) begin
      if (m1_req_i && (!m0_req_i || m1_prio_c)) begin
        gnt1_c  = 1'b1;
        state_d = BUSY_M1;
        cnt_d   = '0;
        we_d    = m1_we_i;
        addr_d  = m1_addr_i;
        wdata_d = m1_wdata_i;
        wstrb_d = m1_we_i ? m1_wstrb_i : '0;
`ifdef ARB_RR_EN
        last_d  = 1'b1;
`endif
      end else if (m0_req_i) begin
        gnt0_c  = 1'b1;
        state_d = BUSY_M0;
        cnt_d   = '0;
        we_d    = 1'b0;
        addr_d  = m0_addr_i;
        wdata_d = '0;
        wstrb_d = '0;
`ifdef ARB_RR_EN
        last_d  = 1'b0;
`endif
      end
    end
  end

  // State and datapath registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
      err_q   <= 1'b0;
      rd0_q   <= '0;
      rd1_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
`ifdef ARB_RR_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rv0_q   <= rv0_d;
      rv1_q   <= rv1_d;
      err_q   <= err_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
`ifdef ARB_RR_EN
      last_q  <= last_d;
`endif
    end
  end

  // Grants are combinational and suppressed while reset is asserted
  assign m0_gnt_o      = gnt0_c & ~rst_n;
  assign m1_gnt_o      = gnt1_c & ~rst_n;
  assign fetch_stall_o = m0_req_i & ~m0_gnt_o;

  assign m0_rvalid_o = rv0_q;
  assign m0_rdata_o  = rd0_q;
  assign m1_rvalid_o = rv1_q;
  assign m1_rdata_o  = rd1_q;
  assign err_o       = err_q;
  assign s_req_o     = (state_q != IDLE);
  assign s_we_o      = we_q;
  assign s_addr_o    = addr_q;
  assign s_wdata_o   = wdata_q;
  assign s_wstrb_o   = wstrb_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed table-driven bench for mem_arbiter (TIMEOUT=4), plus a tie-arbitration sequence.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req_i, m1_req_i, m1_we_i, s_ack_i;
  logic [31:0] m0_addr_i, m1_addr_i, m1_wdata_i, s_rdata_i;
  logic [3:0]  m1_wstrb_i;
  logic        m0_gnt_o, m0_rvalid_o, m1_gnt_o, m1_rvalid_o;
  logic [31:0] m0_rdata_o, m1_rdata_o, s_addr_o, s_wdata_o;
  logic        s_req_o, s_we_o, err_o, fetch_stall_o;
  logic [3:0]  s_wstrb_o;

  mem_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i), .m0_gnt_o(m0_gnt_o),
    .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i),
    .m1_wdata_i(m1_wdata_i), .m1_wstrb_i(m1_wstrb_i), .m1_gnt_o(m1_gnt_o),
    .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
    .s_req_o(s_req_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o),
    .s_wdata_o(s_wdata_o), .s_wstrb_o(s_wstrb_o),
    .s_ack_i(s_ack_i), .s_rdata_i(s_rdata_i),
    .err_o(err_o), .fetch_stall_o(fetch_stall_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, r0;
    logic [31:0] a0;
    logic        r1, we;
    logic [31:0] a1, wd;
    logic [3:0]  ws;
    logic        ack;
    logic [31:0] rd;
  } in_t;

  typedef struct packed {
    logic        g0, g1, rv0, rv1;
    logic [31:0] rd0, rd1;
    logic        sreq, swe;
    logic [31:0] saddr, swd;
    logic [3:0]  sws;
    logic        err, stall;
  } exp_t;

  typedef struct {
    in_t  i;
    exp_t e;
  } vec_t;

  localparam int NV = 29;
  vec_t vecs [NV];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic in_t vi(logic rst, logic r0, logic [31:0] a0, logic r1, logic we,
                             logic [31:0] a1, logic [31:0] wd, logic [3:0] ws,
                             logic ack, logic [31:0] rd);
    in_t t;
    t.rst = rst; t.r0 = r0; t.a0 = a0; t.r1 = r1; t.we = we;
    t.a1 = a1; t.wd = wd; t.ws = ws; t.ack = ack; t.rd = rd;
    return t;
  endfunction

  function automatic exp_t ve(logic g0, logic g1, logic rv0, logic rv1,
                              logic [31:0] rd0, logic [31:0] rd1, logic sreq, logic swe,
                              logic [31:0] saddr, logic [31:0] swd, logic [3:0] sws,
                              logic err, logic stall);
    exp_t t;
    t.g0 = g0; t.g1 = g1; t.rv0 = rv0; t.rv1 = rv1; t.rd0 = rd0; t.rd1 = rd1;
    t.sreq = sreq; t.swe = swe; t.saddr = saddr; t.swd = swd; t.sws = sws;
    t.err = err; t.stall = stall;
    return t;
  endfunction

  task automatic drive(input in_t t);
    rst_n = t.rst; m0_req_i = t.r0; m0_addr_i = t.a0; m1_req_i = t.r1; m1_we_i = t.we;
    m1_addr_i = t.a1; m1_wdata_i = t.wd; m1_wstrb_i = t.ws; s_ack_i = t.ack; s_rdata_i = t.rd;
  endtask

  function automatic exp_t sample();
    return ve(m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, m0_rdata_o, m1_rdata_o,
              s_req_o, s_we_o, s_addr_o, s_wdata_o, s_wstrb_o, err_o, fetch_stall_o);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  in_t  idle_i;
  in_t  h;
  exp_t got;

  initial begin
    idle_i = vi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // reset, then single fetch at 0x100 acked 3 cycles after s_req_o rises
    vecs[0]  = '{vi(1,0,0,0,0,0,0,0,0,0), ve(0,0,0,0,0,0,0,0,0,0,0,0,0)};
    vecs[1]  = '{vi(0,1,32'h100,0,0,0,0,0,0,0), ve(1,0,0,0,0,0,0,0,0,0,0,0,0)};
    vecs[2]  = '{idle_i, ve(0,0,0,0,0,0,1,0,32'h100,0,0,0,0)};
    vecs[3]  = '{idle_i, ve(0,0,0,0,0,0,1,0,32'h100,0,0,0,0)};
    vecs[4]  = '{idle_i, ve(0,0,0,0,0,0,1,0,32'h100,0,0,0,0)};
    vecs[5]  = '{vi(0,0,0,0,0,0,0,0,1,32'hDEADBEEF), ve(0,0,0,0,0,0,1,0,32'h100,0,0,0,0)};
    vecs[6]  = '{idle_i, ve(0,0,1,0,32'hDEADBEEF,0,0,0,32'h100,0,0,0,0)};
    vecs[7]  = '{idle_i, ve(0,0,0,0,32'hDEADBEEF,0,0,0,32'h100,0,0,0,0)};
    // simultaneous requests: m1 first, m0 granted in m1's ack cycle
    vecs[8]  = '{vi(0,1,32'h200,1,0,32'h300,0,0,0,0), ve(0,1,0,0,32'hDEADBEEF,0,0,0,32'h100,0,0,0,1)};
    vecs[9]  = '{vi(0,1,32'h200,0,0,0,0,0,0,0), ve(0,0,0,0,32'hDEADBEEF,0,1,0,32'h300,0,0,0,1)};
    vecs[10] = '{vi(0,1,32'h200,0,0,0,0,0,1,32'hAAAA5555), ve(1,0,0,0,32'hDEADBEEF,0,1,0,32'h300,0,0,0,0)};
    vecs[11] = '{idle_i, ve(0,0,0,1,32'hDEADBEEF,32'hAAAA5555,1,0,32'h200,0,0,0,0)};
    vecs[12] = '{vi(0,0,0,0,0,0,0,0,1,32'h11111111), ve(0,0,0,0,32'hDEADBEEF,32'hAAAA5555,1,0,32'h200,0,0,0,0)};
    vecs[13] = '{idle_i, ve(0,0,1,0,32'h11111111,32'hAAAA5555,0,0,32'h200,0,0,0,0)};
    // store with inputs scrambled after grant; stray ack in IDLE ignored
    vecs[14] = '{vi(0,0,0,1,1,32'h2000,32'h12345678,4'b0011,1,32'hBAD), ve(0,1,0,0,32'h11111111,32'hAAAA5555,0,0,32'h200,0,0,0,0)};
    vecs[15] = '{vi(0,0,0,0,0,32'hFFFF,0,4'hF,0,0), ve(0,0,0,0,32'h11111111,32'hAAAA5555,1,1,32'h2000,32'h12345678,4'b0011,0,0)};
    vecs[16] = '{vi(0,0,0,0,0,32'hFFFF,0,4'hF,0,0), ve(0,0,0,0,32'h11111111,32'hAAAA5555,1,1,32'h2000,32'h12345678,4'b0011,0,0)};
    vecs[17] = '{vi(0,0,0,0,0,32'hFFFF,0,4'hF,1,32'h55), ve(0,0,0,0,32'h11111111,32'hAAAA5555,1,1,32'h2000,32'h12345678,4'b0011,0,0)};
    vecs[18] = '{idle_i, ve(0,0,0,1,32'h11111111,32'h55,0,1,32'h2000,32'h12345678,4'b0011,0,0)};
    // fetch never acked: timeout after 4 busy cycles; m1 waits, granted once IDLE
    vecs[19] = '{vi(0,1,32'h400,0,0,0,0,0,0,0), ve(1,0,0,0,32'h11111111,32'h55,0,1,32'h2000,32'h12345678,4'b0011,0,0)};
    vecs[20] = '{idle_i, ve(0,0,0,0,32'h11111111,32'h55,1,0,32'h400,0,0,0,0)};
    vecs[21] = '{idle_i, ve(0,0,0,0,32'h11111111,32'h55,1,0,32'h400,0,0,0,0)};
    vecs[22] = '{vi(0,0,0,1,0,32'h500,0,0,0,0), ve(0,0,0,0,32'h11111111,32'h55,1,0,32'h400,0,0,0,0)};
    vecs[23] = '{vi(0,0,0,1,0,32'h500,0,0,0,0), ve(0,0,0,0,32'h11111111,32'h55,1,0,32'h400,0,0,0,0)};
    vecs[24] = '{vi(0,0,0,1,0,32'h500,0,0,0,0), ve(0,1,1,0,0,32'h55,0,0,32'h400,0,0,1,0)};
    vecs[25] = '{idle_i, ve(0,0,0,0,0,32'h55,1,0,32'h500,0,0,0,0)};
    // reset mid-busy, then a late ack
    vecs[26] = '{vi(1,0,0,0,0,0,0,0,0,0), ve(0,0,0,0,0,32'h55,1,0,32'h500,0,0,0,0)};
    vecs[27] = '{vi(0,0,0,0,0,0,0,0,1,32'h77), ve(0,0,0,0,0,0,0,0,0,0,0,0,0)};
    vecs[28] = '{idle_i, ve(0,0,0,0,0,0,0,0,0,0,0,0,0)};

    drive(vi(1,0,0,0,0,0,0,0,0,0));
    repeat (2) @(posedge clk);

    for (int k = 0; k < NV; k++) begin
      @(negedge clk);
      drive(vecs[k].i);
      #1;
      got = sample();
      n_cmp++;
      if (got !== vecs[k].e) begin
        n_bad++;
        $display("FAIL vec%0d: got %h expected %h", k, got, vecs[k].e);
      end
    end

    // Tie sequence from IDLE right after reset
    @(negedge clk);
    h = vi(0,1,32'hA0,1,0,32'hB0,0,0,0,0);
    drive(h);
    #1;
`ifdef ARB_RR_EN
    chk("tie1_g0", 32'(m0_gnt_o), 32'd1);
    chk("tie1_g1", 32'(m1_gnt_o), 32'd0);
`else
    chk("tie1_g0", 32'(m0_gnt_o), 32'd0);
    chk("tie1_g1", 32'(m1_gnt_o), 32'd1);
`endif
    @(negedge clk);
    h.ack = 1'b1; h.rd = 32'h99;
    drive(h);
    #1;
    chk("tie2_g0", 32'(m0_gnt_o), 32'd0);
    chk("tie2_g1", 32'(m1_gnt_o), 32'd1);
    chk("tie2_stall", 32'(fetch_stall_o), 32'd1);
`ifdef ARB_RR_EN
    chk("tie2_addr", s_addr_o, 32'hA0);
`else
    chk("tie2_addr", s_addr_o, 32'hB0);
`endif
    @(negedge clk);
    drive(vi(0,1,32'hA0,0,0,0,0,0,0,0));
    #1;
    chk("tie3_addr", s_addr_o, 32'hB0);
    chk("tie3_g0", 32'(m0_gnt_o), 32'd0);
`ifdef ARB_RR_EN
    chk("tie3_rv0", 32'(m0_rvalid_o), 32'd1);
    chk("tie3_rd0", m0_rdata_o, 32'h99);
`else
    chk("tie3_rv1", 32'(m1_rvalid_o), 32'd1);
    chk("tie3_rd1", m1_rdata_o, 32'h99);
`endif
    @(negedge clk);
    drive(vi(0,1,32'hA0,0,0,0,0,0,1,32'h42));
    #1;
    chk("tie4_g0", 32'(m0_gnt_o), 32'd1);
    @(negedge clk);
    drive(idle_i);
    #1;
    chk("tie5_addr", s_addr_o, 32'hA0);
    chk("tie5_sreq", 32'(s_req_o), 32'd1);
    chk("tie5_rv1", 32'(m1_rvalid_o), 32'd1);
    chk("tie5_rd1", m1_rdata_o, 32'h42);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
